// File: rtl/conv_mac_engine.sv
// 2x2 valid 2D correlation of a 4x4 byte matrix with a 3x3 byte kernel,
// one 8x8 multiply-accumulate per cycle, results handed out over valid/ready.
module conv_mac_engine #(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [127:0]     a_flat,
    input  logic [71:0]      b_flat,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data,
    output logic             out_row,
    output logic             out_col,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, LOAD, MAC, EMIT, DONE} state_t;

    state_t           state_q;
    logic [127:0]     a_q;
    logic [71:0]      b_q;
    logic [ACC_W-1:0] acc_q;
    logic [3:0]       k_q;
    logic [1:0]       idx_q;
    logic             valid_q;
    logic [ACC_W-1:0] data_q;
    logic             row_q;
    logic             col_q;
    logic             busy_q;
    logic             done_q;

    logic [1:0]       m_d;
    logic [1:0]       n_d;
    logic [1:0]       a_row_d;
    logic [1:0]       a_col_d;
    logic [7:0]       a_byte_d;
    logic [7:0]       b_byte_d;
    logic [15:0]      prod_d;
    logic [ACC_W-1:0] sum_d;

    // Kernel tap k selects b[m][n] with m = k/3, n = k%3; b is stored at byte k.
    always_comb begin
        m_d = 2'd0;
        if (k_q >= 4'd6) begin
            m_d = 2'd2;
        end else if (k_q >= 4'd3) begin
            m_d = 2'd1;
        end
        n_d      = 2'(k_q - 4'(m_d) * 4'd3);
        a_row_d  = m_d + {1'b0, idx_q[1]};
        a_col_d  = n_d + {1'b0, idx_q[0]};
        a_byte_d = a_q[{a_row_d, a_col_d, 3'b000} +: 8];
        b_byte_d = b_q[{k_q, 3'b000} +: 8];
        prod_d   = a_byte_d * b_byte_d;
        sum_d    = ((k_q == 4'd0) ? '0 : acc_q) + ACC_W'(prod_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            // NOTE: the operand snapshot is reset with everything else so a
            // frame abandoned by reset can never leak stale operands.
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            row_q   <= 1'b0;
            col_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    a_q     <= a_flat;
                    b_q     <= b_flat;
                    k_q     <= '0;
                    idx_q   <= '0;
                    state_q <= MAC;
                end
                MAC: begin
                    acc_q <= sum_d;
                    if (k_q == 4'd8) begin
                        k_q     <= '0;
                        data_q  <= sum_d;
                        row_q   <= idx_q[1];
                        col_q   <= idx_q[0];
                        valid_q <= 1'b1;
                        state_q <= EMIT;
                    end else begin
                        k_q <= k_q + 4'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        if (idx_q == 2'd3) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= MAC;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Self-checking bench for conv_mac_engine: directed frames plus randomized
// operands and back-pressure, compared against a plain-arithmetic correlation model.
module tb_conv_mac_engine;

    localparam int ACC_W = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [127:0]     a_flat;
    logic [71:0]      b_flat;
    logic             out_ready;
    logic             out_valid;
    logic [ACC_W-1:0] out_data;
    logic             out_row;
    logic             out_col;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    conv_mac_engine #(.ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no summary, required finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", tag, got, exp);
        end
    endtask

    function automatic int byte_at(input logic [127:0] v, input int idx);
        logic [127:0] t;
        t = v >> (8 * idx);
        return int'(t[7:0]);
    endfunction

    // y[i][j] = sum over m,n of a[i+m][j+n] * b[m][n]
    function automatic int ref_y(input logic [127:0] a, input logic [71:0] b, input int i, input int j);
        int s = 0;
        for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++)
                s += byte_at(a, 4 * (i + m) + j + n) * byte_at({56'd0, b}, 3 * m + n);
        return s;
    endfunction

    // stall < 0 picks a random back-pressure length for every result.
    task automatic run_frame(input string name, input logic [127:0] a, input logic [71:0] b,
                             input int exp_y[4], input int stall, input bit perturb);
        int cyc;
        int guard;
        int st;
        int total_stall;
        int seen;
        logic [ACC_W-1:0] held;
        a_flat    = a;
        b_flat    = b;
        out_ready = (stall == 0);
        start     = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        cyc         = 0;
        total_stall = 0;
        for (int r = 0; r < 4; r++) begin
            guard = 0;
            while (!out_valid && guard < 100) begin
                if (perturb && cyc == 3) begin
                    a_flat = {4{$urandom()}};
                    b_flat = {8'($urandom()), 32'($urandom()), 32'($urandom())};
                    start  = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                cyc++;
                guard++;
            end
            start = 1'b0;
            if (!out_valid) begin
                check($sformatf("%s_timeout%0d", name, r), 0, 1);
                return;
            end
            if (r == 0) check($sformatf("%s_first_latency", name), cyc, 10);
            check($sformatf("%s_data%0d", name, r), out_data, exp_y[r]);
            check($sformatf("%s_row%0d", name, r), out_row, r / 2);
            check($sformatf("%s_col%0d", name, r), out_col, r % 2);
            st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            total_stall += st;
            held = out_data;
            for (int s = 0; s < st; s++) begin
                out_ready = 1'b0;
                @(posedge clk); #1;
                cyc++;
                check($sformatf("%s_hold_valid%0d", name, r), out_valid, 1);
                check($sformatf("%s_hold_data%0d", name, r), out_data, held);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (stall != 0) out_ready = 1'b0;
        end
        check($sformatf("%s_done_pulse", name), done, 1);
        check($sformatf("%s_valid_low_in_done", name), out_valid, 0);
        if (perturb) start = 1'b1;
        @(posedge clk); #1;
        cyc++;
        start = 1'b0;
        check($sformatf("%s_done_clear", name), done, 0);
        check($sformatf("%s_busy_idle", name), busy, 0);
        check($sformatf("%s_frame_len", name), cyc, 42 + total_stall);
        if (perturb) begin
            seen = 0;
            repeat (12) begin
                @(posedge clk); #1;
                if (busy || out_valid) seen = 1;
            end
            check($sformatf("%s_no_restart", name), seen, 0);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        int a29[16] = '{9, 1, 10, 5, 10, 6, 10, 1, 8, 6, 10, 10, 1, 3, 1, 8};
        int b29[9]  = '{2, 5, 5, 5, 3, 5, 4, 0, 4};
        int e29[4]  = '{263, 206, 216, 221};
        int e255[4] = '{585225, 585225, 585225, 585225};
        int ezero[4] = '{0, 0, 0, 0};
        int erand[4];
        logic [127:0] a_dir;
        logic [71:0]  b_dir;
        logic [127:0] a_r;
        logic [71:0]  b_r;
        int cyc;
        int seen;

        for (int i = 0; i < 16; i++) a_dir[8*i +: 8] = 8'(a29[i]);
        for (int i = 0; i < 9; i++)  b_dir[8*i +: 8] = 8'(b29[i]);

        rst = 1'b1; start = 1'b0; out_ready = 1'b0; a_flat = '0; b_flat = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame("basic", a_dir, b_dir, e29, 0, 1'b0);
        run_frame("sat255", '1, '1, e255, 0, 1'b0);
        run_frame("stall5", a_dir, b_dir, e29, 5, 1'b0);
        run_frame("perturb", a_dir, b_dir, e29, 0, 1'b1);

        // Reset during the second result's MAC phase.
        a_flat = a_dir; b_flat = b_dir; out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 14) begin
            @(posedge clk); #1;
            cyc++;
        end
        rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rowcol", {out_row, out_col}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (busy || out_valid) seen = 1;
        end
        check("midrst_no_stale", seen, 0);
        run_frame("after_rst", a_dir, b_dir, e29, 0, 1'b0);

        run_frame("bzero", {4{$urandom()}}, '0, ezero, 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            a_r = {$urandom(), $urandom(), $urandom(), $urandom()};
            b_r = {8'($urandom()), 32'($urandom()), 32'($urandom())};
            for (int r = 0; r < 4; r++) erand[r] = ref_y(a_r, b_r, r / 2, r % 2);
            run_frame($sformatf("rand%0d", t), a_r, b_r, erand, -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_mac_engine.md
CONV_MAC_ENGINE -- requirements
Module: conv_mac_engine

Interface
REQ-001 Parameter ACC_W, default 20, SHALL set the result width; values below 20 are unsupported (20 bits holds 9*255*255 = 585225).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to compute one 2x2 result frame; sampled only in IDLE.
REQ-005 a_flat  input  128  4x4 input matrix; element a[r][c] occupies bits [8*(4r+c)+7 : 8*(4r+c)], unsigned.
REQ-006 b_flat  input  72  3x3 kernel; element b[m][n] occupies bits [8*(3m+n)+7 : 8*(3m+n)], unsigned.
REQ-007 out_ready  input  1  downstream accepts the result when high together with out_valid.
REQ-008 out_valid  output  1  out_data/out_row/out_col hold a valid result.
REQ-009 out_data  output  ACC_W  result y[out_row][out_col], unsigned.
REQ-010 out_row  output  1  result row index.
REQ-011 out_col  output  1  result column index.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the fourth result is accepted.

Function
REQ-014 The engine SHALL compute valid 2D correlation y[i][j] = sum over m,n in 0..2 of a[i+m][j+n]*b[m][n], for i,j in 0..1, with no kernel flip.
REQ-015 The FSM SHALL have the states IDLE, LOAD, MAC, EMIT and DONE.
REQ-016 IDLE->LOAD when start=1; LOAD->MAC after 1 cycle; MAC->EMIT after exactly 9 cycles; EMIT->MAC when out_valid&&out_ready and the result is not the last; EMIT->DONE on acceptance of the fourth result; DONE->IDLE after 1 cycle.
REQ-017 LOAD SHALL snapshot a_flat and b_flat into internal registers; input changes after LOAD SHALL NOT affect the frame in progress.
REQ-018 MAC SHALL perform one 8x8 multiply and one accumulate per cycle, k = 0..8 (m = k/3, n = k%3), with the accumulator cleared at the first MAC cycle of each result.
REQ-019 Accumulation SHALL be full-precision unsigned at ACC_W bits; overflow cannot occur at ACC_W >= 20.
REQ-020 Results SHALL be emitted in raster order (0,0), (0,1), (1,0), (1,1).
REQ-021 Latency: the first out_valid SHALL rise 10 cycles after the edge that samples start; with out_ready held high, each following result SHALL rise 10 cycles after the previous one.
REQ-022 In EMIT, out_valid SHALL stay high and out_data/out_row/out_col SHALL stay stable until accepted; out_ready low stalls indefinitely.
REQ-023 out_valid SHALL be low in all states other than EMIT; out_data SHALL hold its last value outside EMIT.
REQ-024 start SHALL be ignored in LOAD, MAC, EMIT and DONE; it is not queued.
REQ-025 done SHALL be high only during the DONE cycle; a start asserted in that cycle SHALL be ignored.
REQ-026 The frame SHALL finish with out_ready=1 in 42 cycles from the start-sampling edge until the return to IDLE.

Reset
REQ-027 While rst=1, the engine SHALL immediately enter IDLE and force out_valid=0, busy=0, done=0, out_data=0, out_row=0, out_col=0, accumulator=0 and the MAC counter=0.
REQ-028 An assertion of rst mid-frame SHALL abandon the frame; after release, no stale result SHALL be emitted and a new start SHALL be required.

Verification
REQ-029 Load A rows {9,1,10,5},{10,6,10,1},{8,6,10,10},{1,3,1,8} and B rows {2,5,5},{5,3,5},{4,0,4}, pulse start, out_ready=1 -> outputs 263, 206, 216, 221 at (0,0),(0,1),(1,0),(1,1); done is pulsed once.
REQ-030 Apply all-255 operands -> the four results are each 585225, with no wrap.
REQ-031 Same stimulus as REQ-029 with out_ready low for 5 cycles at each EMIT -> out_valid and out_data are held stable, the results are unchanged, and the frame is 20 cycles longer.
REQ-032 Change a_flat/b_flat and re-pulse start during MAC -> the results match the operands snapshotted at LOAD, and no second frame starts.
REQ-033 Assert rst during the second MAC phase -> all outputs are 0 within the same cycle; after release, there is no out_valid until a new start, and that frame yields the correct results.
REQ-034 Set b_flat=0 -> four results of 0 with normal handshake timing (first out_valid 10 cycles after start).
